// File: rtl/rv32i_pkg.sv
// RV32I shared definitions: opcodes, ALU/writeback selectors and the
// control bundle carried from decode into execute.
package rv32i_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_e;

    localparam logic ASEL_RS1 = 1'b0;
    localparam logic ASEL_PC  = 1'b1;
    localparam logic BSEL_RS2 = 1'b0;
    localparam logic BSEL_IMM = 1'b1;

    typedef struct packed {
        alu_op_e alu_op;
        logic    asel;
        logic    bsel;
        logic    reg_we;
        logic    mem_re;
        logic    mem_we;
        logic    branch;
        logic    jump;
        wb_sel_e wb_sel;
    } ctrl_t;

    // alt selects SUB/SRA; it is ignored for every other funct3
    function automatic alu_op_e alu_from_f3(input logic [2:0] f3,
                                            input logic alt);
        alu_op_e op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/regfile.sv
// Integer register file: two combinational read ports, one write port,
// x0 hardwired to zero, same-cycle write-to-read bypass.
module regfile #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic            wr;

    assign wr = we && (waddr != '0);

    always_comb begin
        regs_d = regs_q;
        if (wr) regs_d[waddr] = wdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rdata1 = regs_q[raddr1];
        if (wr && waddr == raddr1) rdata1 = wdata;
        if (raddr1 == '0) rdata1 = '0;
        rdata2 = regs_q[raddr2];
        if (wr && waddr == raddr2) rdata2 = wdata;
        if (raddr2 == '0) rdata2 = '0;
    end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: regfile, decoder, load-use hazard and ID/EX register.
// Define ILLEGAL_INST_EN to add the registered illegal_out flag.
module id_stage
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [31:0]     inst_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] pcPlus4_in,
    input  logic            flush_in,
    input  logic            wb_we_in,
    input  logic [4:0]      wb_rd_in,
    input  logic [XLEN-1:0] wb_data_in,
    output logic            stall_out,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pcPlus4_out,
    output logic [XLEN-1:0] rs1_data_out,
    output logic [XLEN-1:0] rs2_data_out,
    output logic [XLEN-1:0] imm_out,
    output logic [4:0]      rs1_out,
    output logic [4:0]      rs2_out,
    output logic [4:0]      rd_out,
    output logic [2:0]      funct3_out,
    output logic [3:0]      alu_op_out,
    output logic            asel_out,
    output logic            bsel_out,
    output logic            reg_we_out,
    output logic            mem_re_out,
    output logic            mem_we_out,
    output logic            branch_out,
    output logic            jump_out,
    output logic [1:0]      wb_sel_out
`ifdef ILLEGAL_INST_EN
    ,
    output logic            illegal_out
`endif
);

`ifdef ILLEGAL_INST_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        ctrl_t           ctrl;
    } id_ex_t;

    id_ex_t          ex_q, ex_d;
    ctrl_t           ctrl;
    logic [XLEN-1:0] imm, rdata1, rdata2;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [6:0]      opcode, f7;
    logic [4:0]      rs1, rs2, rd;
    logic [2:0]      f3;
    logic            s, use_rs1, use_rs2, bad;
    logic            hazard, bad_go;

    assign opcode = inst_in[6:0];
    assign rd     = inst_in[11:7];
    assign f3     = inst_in[14:12];
    assign rs1    = inst_in[19:15];
    assign rs2    = inst_in[24:20];
    assign f7     = inst_in[31:25];
    assign s      = inst_in[31];

    assign imm_i = {{(XLEN-12){s}}, inst_in[31:20]};
    assign imm_s = {{(XLEN-12){s}}, inst_in[31:25], inst_in[11:7]};
    assign imm_b = {{(XLEN-13){s}}, inst_in[31], inst_in[7],
                    inst_in[30:25], inst_in[11:8], 1'b0};
    assign imm_u = XLEN'($signed({inst_in[31:12], 12'b0}));
    assign imm_j = {{(XLEN-21){s}}, inst_in[31], inst_in[19:12],
                    inst_in[20], inst_in[30:21], 1'b0};

    regfile #(.XLEN(XLEN), .NREG(NREG), .AW(5)) u_rf (
        .clk    (clk),
        .reset_n(reset_n),
        .we     (wb_we_in),
        .waddr  (wb_rd_in),
        .wdata  (wb_data_in),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rdata1),
        .rdata2 (rdata2)
    );

    always_comb begin
        ctrl    = '0;
        imm     = '0;
        use_rs1 = 1'b1;
        use_rs2 = 1'b0;
        bad     = 1'b0;
        unique case (opcode)
            OPC_LUI: begin
                ctrl.alu_op = ALU_PASS_B;
                ctrl.bsel   = BSEL_IMM;
                ctrl.reg_we = 1'b1;
                imm         = imm_u;
                use_rs1     = 1'b0;
            end
            OPC_AUIPC: begin
                ctrl.asel   = ASEL_PC;
                ctrl.bsel   = BSEL_IMM;
                ctrl.reg_we = 1'b1;
                imm         = imm_u;
                use_rs1     = 1'b0;
            end
            OPC_JAL: begin
                ctrl.asel   = ASEL_PC;
                ctrl.bsel   = BSEL_IMM;
                ctrl.jump   = 1'b1;
                ctrl.wb_sel = WB_PC4;
                ctrl.reg_we = 1'b1;
                imm         = imm_j;
                use_rs1     = 1'b0;
            end
            OPC_JALR: begin
                ctrl.bsel   = BSEL_IMM;
                ctrl.jump   = 1'b1;
                ctrl.wb_sel = WB_PC4;
                ctrl.reg_we = 1'b1;
                imm         = imm_i;
            end
            OPC_BRANCH: begin
                ctrl.asel   = ASEL_PC;
                ctrl.bsel   = BSEL_IMM;
                ctrl.branch = 1'b1;
                imm         = imm_b;
                use_rs2     = 1'b1;
            end
            OPC_LOAD: begin
                ctrl.bsel   = BSEL_IMM;
                ctrl.mem_re = 1'b1;
                ctrl.wb_sel = WB_MEM;
                ctrl.reg_we = 1'b1;
                imm         = imm_i;
            end
            OPC_STORE: begin
                ctrl.bsel   = BSEL_IMM;
                ctrl.mem_we = 1'b1;
                imm         = imm_s;
                use_rs2     = 1'b1;
            end
            OPC_OPIMM: begin
                ctrl.alu_op = alu_from_f3(f3, f3 == 3'b101 && inst_in[30]);
                ctrl.bsel   = BSEL_IMM;
                ctrl.reg_we = 1'b1;
                imm         = imm_i;
                bad = (f3 == 3'b001 && f7 != 7'h00) ||
                      (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20);
            end
            OPC_OP: begin
                ctrl.alu_op = alu_from_f3(f3, inst_in[30]);
                ctrl.reg_we = 1'b1;
                use_rs2     = 1'b1;
                bad = !(f7 == 7'h00 ||
                        (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
            end
            OPC_FENCE, OPC_SYSTEM: ;
            default: bad = 1'b1;
        endcase
    end

    assign hazard = ex_q.ctrl.mem_re && (ex_q.rd != 5'd0) &&
                    ((use_rs1 && ex_q.rd == rs1) ||
                     (use_rs2 && ex_q.rd == rs2));
    assign stall_out = hazard && !flush_in;
    // a stalled illegal instruction is re-decoded next cycle, so flag it then
    assign bad_go = ILL_EN && bad && !flush_in && !hazard;

    always_comb begin
        ex_d = '0;
        if (!(flush_in || hazard || bad_go)) begin
            ex_d.pc       = pc_in;
            ex_d.pc4      = pcPlus4_in;
            ex_d.rs1_data = rdata1;
            ex_d.rs2_data = rdata2;
            ex_d.imm      = imm;
            ex_d.rs1      = rs1;
            ex_d.rs2      = rs2;
            ex_d.rd       = rd;
            ex_d.funct3   = f3;
            ex_d.ctrl     = ctrl;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ex_q <= '0;
        else          ex_q <= ex_d;
    end

`ifdef ILLEGAL_INST_EN
    logic illegal_q, illegal_d;
    assign illegal_d = bad_go;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) illegal_q <= 1'b0;
        else          illegal_q <= illegal_d;
    end
    assign illegal_out = illegal_q;
`endif

    assign pc_out       = ex_q.pc;
    assign pcPlus4_out  = ex_q.pc4;
    assign rs1_data_out = ex_q.rs1_data;
    assign rs2_data_out = ex_q.rs2_data;
    assign imm_out      = ex_q.imm;
    assign rs1_out      = ex_q.rs1;
    assign rs2_out      = ex_q.rs2;
    assign rd_out       = ex_q.rd;
    assign funct3_out   = ex_q.funct3;
    assign alu_op_out   = ex_q.ctrl.alu_op;
    assign asel_out     = ex_q.ctrl.asel;
    assign bsel_out     = ex_q.ctrl.bsel;
    assign reg_we_out   = ex_q.ctrl.reg_we;
    assign mem_re_out   = ex_q.ctrl.mem_re;
    assign mem_we_out   = ex_q.ctrl.mem_we;
    assign branch_out   = ex_q.ctrl.branch;
    assign jump_out     = ex_q.ctrl.jump;
    assign wb_sel_out   = ex_q.ctrl.wb_sel;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: directed cases then random instruction
// streams checked against an ISA-level decode model.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] inst_in = '0, pc_in = '0, pcPlus4_in = '0;
    logic        flush_in = 1'b0, wb_we_in = 1'b0;
    logic [4:0]  wb_rd_in = '0;
    logic [31:0] wb_data_in = '0;

    logic        stall_out;
    logic [31:0] pc_out, pcPlus4_out, rs1_data_out, rs2_data_out, imm_out;
    logic [4:0]  rs1_out, rs2_out, rd_out;
    logic [2:0]  funct3_out;
    logic [3:0]  alu_op_out;
    logic        asel_out, bsel_out, reg_we_out, mem_re_out, mem_we_out;
    logic        branch_out, jump_out;
    logic [1:0]  wb_sel_out;
`ifdef ILLEGAL_INST_EN
    logic        illegal_out;
`endif

    always #5 clk = ~clk;

    id_stage dut (
        .clk(clk), .reset_n(reset_n), .inst_in(inst_in), .pc_in(pc_in),
        .pcPlus4_in(pcPlus4_in), .flush_in(flush_in), .wb_we_in(wb_we_in),
        .wb_rd_in(wb_rd_in), .wb_data_in(wb_data_in), .stall_out(stall_out),
        .pc_out(pc_out), .pcPlus4_out(pcPlus4_out),
        .rs1_data_out(rs1_data_out), .rs2_data_out(rs2_data_out),
        .imm_out(imm_out), .rs1_out(rs1_out), .rs2_out(rs2_out),
        .rd_out(rd_out), .funct3_out(funct3_out), .alu_op_out(alu_op_out),
        .asel_out(asel_out), .bsel_out(bsel_out), .reg_we_out(reg_we_out),
        .mem_re_out(mem_re_out), .mem_we_out(mem_we_out),
        .branch_out(branch_out), .jump_out(jump_out), .wb_sel_out(wb_sel_out)
`ifdef ILLEGAL_INST_EN
        , .illegal_out(illegal_out)
`endif
    );

    typedef struct packed {
        logic [31:0] pc, pc4, r1d, r2d, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic [3:0]  alu;
        logic        asel, bsel, we, mre, mwe, br, jmp;
        logic [1:0]  wbs;
`ifdef ILLEGAL_INST_EN
        logic        ill;
`endif
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e, mon_a;
    int          errors = 0, checks = 0;
    logic [31:0] rf [32];
    logic        prev_mre = 1'b0;
    logic [4:0]  prev_rd = '0;
    logic [31:0] pc = '0;
    logic        ds, es;
    logic [31:0] cur;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t actual();
        exp_t a;
        a.pc = pc_out; a.pc4 = pcPlus4_out;
        a.r1d = rs1_data_out; a.r2d = rs2_data_out; a.imm = imm_out;
        a.rs1 = rs1_out; a.rs2 = rs2_out; a.rd = rd_out;
        a.f3 = funct3_out; a.alu = alu_op_out;
        a.asel = asel_out; a.bsel = bsel_out; a.we = reg_we_out;
        a.mre = mem_re_out; a.mwe = mem_we_out;
        a.br = branch_out; a.jmp = jump_out; a.wbs = wb_sel_out;
`ifdef ILLEGAL_INST_EN
        a.ill = illegal_out;
`endif
        return a;
    endfunction

    task automatic check_zero(input string name);
        exp_t a;
        a = actual();
        checks++;
        if (a !== '0) begin
            errors++;
            $display("FAIL %s: got %h expected all zero", name, a);
        end
    endtask

    function automatic logic [31:0] rd_rf(input logic [4:0] r);
        if (r == 0) return 32'd0;
        if (wb_we_in && wb_rd_in == r) return wb_data_in;
        return rf[r];
    endfunction

    // Decode from the ISA tables, using the current IF/ID inputs
    function automatic exp_t model(input logic [31:0] inst, input logic fl,
                                   output logic st);
        exp_t        e;
        logic [3:0]  tab [8];
        logic [31:0] iimm, simm, bimm, uimm, jimm;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        use1, use2, ill, bub;
        tab = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        e = '0;
        f3 = inst[14:12];
        f7 = inst[31:25];
        e.pc = pc_in; e.pc4 = pcPlus4_in;
        e.rs1 = inst[19:15]; e.rs2 = inst[24:20]; e.rd = inst[11:7];
        e.f3 = f3;
        e.r1d = rd_rf(e.rs1); e.r2d = rd_rf(e.rs2);
        iimm = $signed(inst) >>> 20;
        simm = {iimm[31:5], inst[11:7]};
        bimm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
        uimm = inst & 32'hFFFFF000;
        jimm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
        use1 = 1'b1; use2 = 1'b0; ill = 1'b0;
        case (inst[6:0])
            7'h37: begin e.alu = 4'd10; e.bsel = 1; e.imm = uimm;
                         e.we = 1; use1 = 0; end
            7'h17: begin e.asel = 1; e.bsel = 1; e.imm = uimm;
                         e.we = 1; use1 = 0; end
            7'h6F: begin e.asel = 1; e.bsel = 1; e.imm = jimm; e.jmp = 1;
                         e.wbs = 2; e.we = 1; use1 = 0; end
            7'h67: begin e.bsel = 1; e.imm = iimm; e.jmp = 1;
                         e.wbs = 2; e.we = 1; end
            7'h63: begin e.asel = 1; e.bsel = 1; e.imm = bimm;
                         e.br = 1; use2 = 1; end
            7'h03: begin e.bsel = 1; e.imm = iimm; e.mre = 1;
                         e.wbs = 1; e.we = 1; end
            7'h23: begin e.bsel = 1; e.imm = simm; e.mwe = 1; use2 = 1; end
            7'h13: begin
                e.alu = tab[f3] + ((f3 == 5 && inst[30]) ? 4'd1 : 4'd0);
                e.bsel = 1; e.imm = iimm; e.we = 1;
                ill = (f3 == 1 && f7 != 0) ||
                      (f3 == 5 && f7 != 0 && f7 != 7'h20);
            end
            7'h33: begin
                e.alu = tab[f3] +
                        (((f3 == 0 || f3 == 5) && inst[30]) ? 4'd1 : 4'd0);
                e.we = 1; use2 = 1;
                ill = !(f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)));
            end
            7'h0F, 7'h73: ;
            default: ill = 1'b1;
        endcase
        st = !fl && prev_mre && prev_rd != 0 &&
             ((use1 && prev_rd == e.rs1) || (use2 && prev_rd == e.rs2));
`ifdef ILLEGAL_INST_EN
        ill = ill && !fl && !st;
`else
        ill = 1'b0;
`endif
        bub = fl || st || ill;
        if (bub) e = '0;
`ifdef ILLEGAL_INST_EN
        e.ill = ill;
`endif
        return e;
    endfunction

    task automatic step(input logic [31:0] inst, input logic fl,
                        input logic we, input logic [4:0] wrd,
                        input logic [31:0] wd,
                        output logic dut_st, output logic exp_st);
        exp_t e;
        @(negedge clk);
        inst_in = inst; pc_in = pc; pcPlus4_in = pc + 32'd4;
        flush_in = fl; wb_we_in = we; wb_rd_in = wrd; wb_data_in = wd;
        #1;
        e = model(inst, fl, exp_st);
        dut_st = stall_out;
        check("stall", {31'd0, stall_out}, {31'd0, exp_st});
        q.push_back(e);
        prev_mre = e.mre;
        prev_rd = e.rd;
        if (we && wrd != 0) rf[wrd] = wd;
        if (!exp_st) pc = pc + 32'd4;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) rf[i] = '0;
        prev_mre = 1'b0; prev_rd = '0; pc = '0;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        logic [6:0]  opc;
        r = $urandom;
        r[19:15] = 5'($urandom_range(0, 7));
        r[24:20] = 5'($urandom_range(0, 7));
        r[11:7]  = 5'($urandom_range(0, 7));
        case ($urandom_range(0, 12))
            0: opc = 7'h37;  1: opc = 7'h17;  2: opc = 7'h6F;
            3: opc = 7'h67;  4: opc = 7'h63;  5, 6: opc = 7'h03;
            7: opc = 7'h23;  8: opc = 7'h13;  9: opc = 7'h33;
            10: opc = 7'h0F; 11: opc = 7'h73;
            default: opc = r[6:0];
        endcase
        r[6:0] = opc;
        if (opc == 7'h33 ||
            (opc == 7'h13 && (r[14:12] == 3'd1 || r[14:12] == 3'd5)))
            if ($urandom_range(0, 7) != 0)
                r[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        return r;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (reset_n && q.size() > 0) begin
                mon_e = q.pop_front();
                mon_a = actual();
                checks++;
                if (mon_a !== mon_e) begin
                    errors++;
                    $display("FAIL idex: got %h expected %h", mon_a, mon_e);
                end
            end
        end
    end

    initial begin
        model_reset();
        #3;
        check_zero("reset_outs");
        check("reset_stall", {31'd0, stall_out}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        step(32'h00500093, 0, 0, 0, 0, ds, es);
        after_edge();
        check("addi_imm", imm_out, 32'd5);
        check("addi_alu", {28'd0, alu_op_out}, 32'd0);
        check("addi_bsel", {31'd0, bsel_out}, 32'd1);
        check("addi_rd", {27'd0, rd_out}, 32'd1);
        check("addi_we", {31'd0, reg_we_out}, 32'd1);
        check("addi_rs1d", rs1_data_out, 32'd0);

        step(32'h000101B3, 0, 1, 5'd2, 32'hDEADBEEF, ds, es);
        after_edge();
        check("bypass_rs1d", rs1_data_out, 32'hDEADBEEF);

        step(32'h0000A283, 0, 0, 0, 0, ds, es);
        step(32'h00528333, 0, 0, 0, 0, ds, es);
        check("lu_stall", {31'd0, ds}, 32'd1);
        after_edge();
        check("lu_bubble_we", {31'd0, reg_we_out}, 32'd0);
        step(32'h00528333, 0, 0, 0, 0, ds, es);
        check("lu_release", {31'd0, ds}, 32'd0);
        after_edge();
        check("lu_add_rd", {27'd0, rd_out}, 32'd6);
        check("lu_add_we", {31'd0, reg_we_out}, 32'd1);

        step(32'h0000A283, 0, 0, 0, 0, ds, es);
        step(32'h123452B7, 0, 0, 0, 0, ds, es);
        check("lui_nostall", {31'd0, ds}, 32'd0);
        after_edge();
        check("lui_imm", imm_out, 32'h12345000);

        step(32'hFE000CE3, 1, 0, 0, 0, ds, es);
        after_edge();
        check("flush_ctrl", {29'd0, branch_out, asel_out, bsel_out}, 32'd0);
        step(32'hFE000CE3, 0, 0, 0, 0, ds, es);
        after_edge();
        check("beq_branch", {31'd0, branch_out}, 32'd1);
        check("beq_imm", imm_out, 32'hFFFFFFF8);
        check("beq_asel", {31'd0, asel_out}, 32'd1);

        step(32'h000003B3, 0, 1, 5'd0, 32'hFFFFFFFF, ds, es);
        after_edge();
        check("x0_bypass", rs1_data_out, 32'd0);
        step(32'h000003B3, 0, 0, 0, 0, ds, es);
        after_edge();
        check("x0_read", rs1_data_out, 32'd0);

`ifdef ILLEGAL_INST_EN
        step(32'hFFFFFFFF, 0, 0, 0, 0, ds, es);
        after_edge();
        check("ill_flag", {31'd0, illegal_out}, 32'd1);
        check("ill_we", {31'd0, reg_we_out}, 32'd0);
        step(32'hFFFFFFFF, 1, 0, 0, 0, ds, es);
        after_edge();
        check("ill_flush", {31'd0, illegal_out}, 32'd0);
`endif

        step(32'h0000A283, 0, 0, 0, 0, ds, es);
        @(negedge clk);
        inst_in = 32'h00528333; flush_in = 0; wb_we_in = 0;
        #1;
        check("midstall_pre", {31'd0, stall_out}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("midstall_stall", {31'd0, stall_out}, 32'd0);
        check_zero("midstall_outs");
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        step(32'h000101B3, 0, 0, 0, 0, ds, es);
        after_edge();
        check("rf_cleared", rs1_data_out, 32'd0);

        es = 1'b0;
        cur = '0;
        for (int n = 0; n < 800; n++) begin
            if (!es) cur = rand_inst();
            step(cur, ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 1) != 0),
                 5'($urandom_range(0, 7)), $urandom, ds, es);
        end

        repeat (2) @(negedge clk);
        check("drain", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
